// File: rtl/crc_frame_ctrl.sv
// rtl/crc_frame_ctrl.sv - frame sequencer for a free-running 8-bit CRC engine
// Buffers one frame, clears the engine, streams the frame gap-free and returns the captured CRC.
module crc_frame_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             eng_rst,
  output logic [7:0]       eng_din,
  input  logic [7:0]       eng_crc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_crc,
  output logic             m_ok,
  output logic [LEN_W-1:0] m_len,
  output logic             m_err
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_LOAD, S_CLEAR, S_FEED, S_AUG, S_CAPTURE, S_DONE_ERR, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] wr_cnt, rd_cnt;
  logic             ovf, mode_q;
  logic [7:0]       frame_buf [2**IDX_W];
  logic             hs, full, feed_last;

  // Handshake derived from state, not s_ready, to keep the comb logic acyclic.
  assign hs        = s_valid && (state == S_LOAD);
  assign full      = (wr_cnt == LEN_W'(MAX_LEN));
  assign feed_last = (rd_cnt == wr_cnt - LEN_W'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    eng_din   = 8'h00;
    eng_rst   = RST;
    case (state)
      S_LOAD: begin
        s_ready = 1'b1;
        if (hs && s_last) state_nxt = (ovf || full) ? S_DONE_ERR : S_CLEAR;
      end
      S_CLEAR: begin
        eng_rst   = 1'b1;
        state_nxt = S_FEED;
      end
      S_FEED: begin
        eng_din = frame_buf[rd_cnt[IDX_W-1:0]];
        if (feed_last) state_nxt = mode_q ? S_CAPTURE : S_AUG;
      end
      S_AUG:      state_nxt = S_CAPTURE;
      S_CAPTURE:  state_nxt = S_DONE;
      S_DONE_ERR: state_nxt = S_DONE;
      S_DONE: begin
        if (m_valid && m_ready) state_nxt = S_LOAD;
      end
      default:    state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (hs && !full) frame_buf[wr_cnt[IDX_W-1:0]] <= s_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      ovf     <= 1'b0;
      mode_q  <= 1'b0;
      m_valid <= 1'b0;
      m_crc   <= 8'h00;
      m_ok    <= 1'b0;
      m_len   <= '0;
      m_err   <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (hs) begin
            if (wr_cnt == '0 && !ovf) mode_q <= mode;
            // Bytes past the buffer depth are dropped; the frame is reported as an error.
            if (full) ovf    <= 1'b1;
            else      wr_cnt <= wr_cnt + LEN_W'(1);
          end
        end
        S_CLEAR: rd_cnt <= '0;
        S_FEED:  rd_cnt <= rd_cnt + LEN_W'(1);
        S_CAPTURE: begin
          m_crc   <= eng_crc;
          m_ok    <= mode_q ? (eng_crc == 8'h00) : 1'b1;
          m_len   <= wr_cnt;
          m_err   <= 1'b0;
          m_valid <= 1'b1;
        end
        S_DONE_ERR: begin
          m_crc   <= 8'h00;
          m_ok    <= 1'b0;
          m_err   <= 1'b1;
          m_len   <= LEN_W'(MAX_LEN);
          m_valid <= 1'b1;
        end
        S_DONE: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            wr_cnt  <= '0;
            ovf     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// tb/tb_crc_frame_ctrl.sv - bench for crc_frame_ctrl with a behavioural CRC-8 engine
module tb_crc_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             CLK, RST, mode, s_valid, s_ready, s_last;
  logic [7:0]       s_data, eng_din, eng_crc, m_crc;
  logic             eng_rst, m_valid, m_ready, m_ok, m_err;
  logic [LEN_W-1:0] m_len;

  crc_frame_ctrl #(.MAX_LEN(MAX_LEN)) dut (
    .CLK(CLK), .RST(RST), .mode(mode), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .eng_rst(eng_rst), .eng_din(eng_din),
    .eng_crc(eng_crc), .m_valid(m_valid), .m_ready(m_ready), .m_crc(m_crc),
    .m_ok(m_ok), .m_len(m_len), .m_err(m_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Augmented shift-register engine, poly x^8+x^2+x+1, bit7 shifted in first.
  always @(posedge CLK) begin
    if (eng_rst) eng_crc <= 8'h00;
    else begin
      logic [7:0] c;
      logic       msb;
      c = eng_crc;
      for (int b = 7; b >= 0; b--) begin
        msb = c[7];
        c   = {c[6:0], eng_din[b]};
        if (msb) c = c ^ 8'h07;
      end
      eng_crc <= c;
    end
  end

  typedef struct {
    bit               md;
    int               n;
    logic [19:0][7:0] d;
    int               gap;
    int               hold;
    logic [7:0]       ecrc;
    bit               eok;
    int               elen;
    bit               eerr;
    int               elat;
  } vec_t;

  vec_t vt[8];
  int   passed = 0;
  int   total  = 0;

  // Direct (non-augmented) CRC-8 reference, equal to the augmented engine result.
  function automatic logic [7:0] crc8_ref(input logic [19:0][7:0] d, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ d[i][b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic send_frame(input vec_t v, output int k);
    int guard;
    k = 0;
    for (int i = 0; i < v.n; i++) begin
      repeat ($urandom_range(0, v.gap)) begin
        s_valid = 1'b0;
        s_data  = 8'hxx;
        @(negedge CLK);
      end
      s_valid = 1'b1;
      s_data  = v.d[i];
      s_last  = (i == v.n - 1);
      mode    = (i == 0) ? v.md : ~v.md;
      guard   = 0;
      while (!s_ready && guard < 50) begin
        @(negedge CLK);
        guard++;
      end
      if (guard == 50) chk("s_ready_timeout", 0, 1);
      @(posedge CLK);
      @(negedge CLK);
      k       = cyc;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic run_vec(input int vi);
    vec_t             v;
    int               k, guard, nexp;
    bit               ok;
    logic [7:0]       exp_b, snap_crc;
    logic [LEN_W-1:0] snap_len;
    logic             snap_ok, snap_err;
    v       = vt[vi];
    m_ready = (v.hold == 0);
    send_frame(v, k);
    ok = 1'b1;
    if (!v.eerr) begin
      chk($sformatf("v%0d_eng_rst_clear", vi), eng_rst, 1);
      nexp = v.n + (v.md ? 0 : 1);
      for (int j = 0; j < nexp; j++) begin
        @(negedge CLK);
        exp_b = (j < v.n) ? v.d[j] : 8'h00;
        if (eng_din !== exp_b) ok = 1'b0;
      end
    end
    guard = 0;
    while (!m_valid && guard < 200) begin
      if (v.eerr && (eng_din !== 8'h00 || eng_rst !== 1'b0)) ok = 1'b0;
      @(negedge CLK);
      guard++;
    end
    chk($sformatf("v%0d_engine_stream", vi), ok, 1);
    chk($sformatf("v%0d_m_valid", vi), m_valid, 1);
    chk($sformatf("v%0d_latency", vi), cyc - k, v.elat);
    chk($sformatf("v%0d_m_crc", vi), m_crc, v.ecrc);
    chk($sformatf("v%0d_m_ok", vi), m_ok, v.eok);
    chk($sformatf("v%0d_m_len", vi), m_len, v.elen);
    chk($sformatf("v%0d_m_err", vi), m_err, v.eerr);
    if (v.hold > 0) begin
      snap_crc = m_crc; snap_len = m_len; snap_ok = m_ok; snap_err = m_err;
      ok = 1'b1;
      repeat (v.hold) begin
        @(negedge CLK);
        if (!m_valid || s_ready || m_crc !== snap_crc || m_len !== snap_len ||
            m_ok !== snap_ok || m_err !== snap_err) ok = 1'b0;
      end
      chk($sformatf("v%0d_backpressure_hold", vi), ok, 1);
      m_ready = 1'b1;
    end
    @(negedge CLK);
    chk($sformatf("v%0d_m_valid_cleared", vi), m_valid, 0);
    chk($sformatf("v%0d_s_ready_back", vi), s_ready, 1);
  endtask

  initial begin
    logic [7:0]       b8 [8];
    logic [7:0]       gcrc;
    int               k;
    bit               ok;
    b8 = '{8'hFE, 8'h9B, 8'h53, 8'h96, 8'h0C, 8'h7D, 8'h43, 8'h5C};

    for (int i = 0; i < 8; i++) begin
      vt[i].d = '0; vt[i].gap = 0; vt[i].hold = 0; vt[i].eerr = 0; vt[i].eok = 1;
    end
    vt[0].md = 0; vt[0].n = 1; vt[0].d[0] = 8'h00; vt[0].ecrc = 8'h00;
    vt[0].elen = 1; vt[0].elat = 4;

    vt[1].md = 0; vt[1].n = 8; vt[1].gap = 3;
    for (int i = 0; i < 8; i++) vt[1].d[i] = b8[i];
    gcrc = crc8_ref(vt[1].d, 8);
    vt[1].ecrc = gcrc; vt[1].elen = 8; vt[1].elat = 11;

    vt[2] = vt[1]; vt[2].md = 1; vt[2].n = 9; vt[2].gap = 1; vt[2].d[8] = gcrc;
    vt[2].ecrc = 8'h00; vt[2].elen = 9; vt[2].elat = 11;

    vt[3] = vt[2]; vt[3].d[3] = vt[3].d[3] ^ 8'h01;
    vt[3].ecrc = crc8_ref(vt[3].d, 8) ^ gcrc; vt[3].eok = 0;

    vt[4].md = 0; vt[4].n = MAX_LEN + 2;
    for (int i = 0; i < MAX_LEN + 2; i++) vt[4].d[i] = 8'(i * 7 + 1);
    vt[4].ecrc = 8'h00; vt[4].eok = 0; vt[4].elen = MAX_LEN; vt[4].eerr = 1; vt[4].elat = 1;

    vt[5].md = 0; vt[5].n = 1; vt[5].d[0] = 8'hA5;
    vt[5].ecrc = crc8_ref(vt[5].d, 1); vt[5].elen = 1; vt[5].elat = 4;

    vt[6].md = 0; vt[6].n = MAX_LEN; vt[6].gap = 1; vt[6].hold = 10;
    for (int i = 0; i < MAX_LEN; i++) vt[6].d[i] = 8'hF0 ^ 8'(i);
    vt[6].ecrc = crc8_ref(vt[6].d, MAX_LEN); vt[6].elen = MAX_LEN; vt[6].elat = MAX_LEN + 3;

    vt[7].md = 1; vt[7].n = 1; vt[7].d[0] = 8'h00; vt[7].ecrc = 8'h00;
    vt[7].elen = 1; vt[7].elat = 3;

    RST = 1'b1; mode = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_eng_rst", eng_rst, 1);
    chk("rst_eng_din", eng_din, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_outputs", {m_crc, m_ok, 3'b0, m_len, m_err}, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_eng_rst", eng_rst, 0);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset pulse while the engine is being fed.
    m_ready = 1'b1;
    send_frame(vt[1], k);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst_async_eng_rst", eng_rst, 1);
    chk("rst_async_m_valid", m_valid, 0);
    @(negedge CLK);
    RST = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (m_valid !== 1'b0 || s_ready !== 1'b1) ok = 1'b0;
    end
    chk("rst_abort_no_result", ok, 1);
    run_vec(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
